// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter that shares one SPI master between NUM_REQ requesters, sequencing mode setup, trans, SCK edge counting and the inter-transfer gap.
// Optional XFER watchdog: define SPI_XFER_ARBITER_TIMEOUT_EN.
module spi_xfer_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int BITS        = 16,
  parameter int SETUP_CYC   = 4,
  parameter int GAP_CYC     = 8,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_ckp,
  input  logic [NUM_REQ-1:0] req_cph,
  input  logic               SCK,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] done,
  output logic               trans,
  output logic               CKP,
  output logic               CPH,
  output logic               busy,
  output logic               err,
  output logic [1:0]         dbg_state
);

  // Handshake: req is a level request; the arbiter answers with a one-hot gnt held
  // from SETUP through HOLD and a single-cycle done pulse. Dropping req after gnt
  // does not abort, and a request is only considered again from IDLE.

  localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CMAX = (BITS > SETUP_CYC) ? ((BITS > GAP_CYC) ? BITS : GAP_CYC)
                                           : ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC);
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      winner, cand;
  logic               found;
  logic               sck_q;
  logic               lead;
  logic [NUM_REQ-1:0] gnt_d, done_d;
  logic               trans_d, ckp_d, cph_d, busy_d;

`ifdef SPI_XFER_ARBITER_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  logic [WW-1:0] wdog_q, wdog_d;
  logic          err_d;
`endif

  assign dbg_state = state_q;
  assign lead      = (sck_q == CKP) && (SCK != CKP);

  // Search starts just after the last winner so service rotates strictly.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = PW'((int'(ptr_q) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt;
    done_d  = '0;
    trans_d = trans;
    ckp_d   = CKP;
    cph_d   = CPH;
    busy_d  = busy;
`ifdef SPI_XFER_ARBITER_TIMEOUT_EN
    err_d   = 1'b0;
    wdog_d  = (state_q == XFER) ? wdog_q + WW'(1) : '0;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d         = '0;
          gnt_d[winner] = 1'b1;
          ckp_d         = req_ckp[winner];
          cph_d         = req_cph[winner];
          ptr_d         = winner;
          busy_d        = 1'b1;
          cnt_d         = '0;
          state_d       = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == CW'(SETUP_CYC - 1)) begin
          cnt_d   = '0;
          trans_d = 1'b1;
          state_d = XFER;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      XFER: begin
        // Completion waits for SCK to settle back at its idle level after the last edge.
        if (cnt_q == CW'(BITS) && SCK == CKP) begin
          trans_d = 1'b0;
          done_d  = gnt;
          cnt_d   = '0;
          state_d = HOLD;
`ifdef SPI_XFER_ARBITER_TIMEOUT_EN
        end else if (wdog_q == WW'(TIMEOUT_CYC - 1)) begin
          trans_d = 1'b0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = HOLD;
`endif
        end else if (lead && cnt_q < CW'(BITS)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (cnt_q == CW'(GAP_CYC - 1)) begin
          gnt_d   = '0;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= PW'(NUM_REQ - 1);
      sck_q   <= 1'b0;
      gnt     <= '0;
      done    <= '0;
      trans   <= 1'b0;
      CKP     <= 1'b0;
      CPH     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      sck_q   <= SCK;
      gnt     <= gnt_d;
      done    <= done_d;
      trans   <= trans_d;
      CKP     <= ckp_d;
      CPH     <= cph_d;
      busy    <= busy_d;
    end
  end

`ifdef SPI_XFER_ARBITER_TIMEOUT_EN
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      wdog_q <= '0;
      err    <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err    <= err_d;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
